lieat_ifu_ibuf: RTL and testbench

Instruction buffer between the fetch unit's memory response path and the decode stage (`lieat_idu`). It queues fetched `{pc, inst, prdt_taken}` triples and presents them on the decode `id_i_*` valid/ready handshake. It issues fetch credits so that responses never need back-pressure. After a flush it discards responses belonging to in-flight pre-flush requests.

---
 rtl/lieat_ifu_ibuf.sv | 134 +++++++++++++
 tb/tb_lieat_ifu_ibuf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lieat_ifu_ibuf.sv
// Instruction buffer between fetch responses and decode, with credit-based flow control
// and post-flush response dropping. Optional same-cycle bypass: LIEAT_IBUF_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module lieat_ifu_ibuf #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_req,
  output logic              ifu_req_credit,
  input  logic              ifu_req_sh,
  input  logic              ifu_rsp_valid,
  input  logic [`XLEN-1:0]  ifu_rsp_pc,
  input  logic [`XLEN-1:0]  ifu_rsp_inst,
  input  logic              ifu_rsp_prdt_taken,
  output logic              id_i_valid,
  input  logic              id_i_ready,
  output logic [`XLEN-1:0]  id_i_pc,
  output logic [`XLEN-1:0]  id_i_inst,
  output logic              id_i_prdt_taken,
  output logic              ibuf_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [AW:0]        wr_ptr_r, rd_ptr_r, fifo_cnt_s;
  logic [CW-1:0]      outst_cnt_r, drop_cnt_r;
  logic [`XLEN-1:0]   pc_mem_r   [DEPTH];
  logic [`XLEN-1:0]   inst_mem_r [DEPTH];
  logic [DEPTH-1:0]   taken_mem_r;
  logic [31:0]        occ_s;
  logic               empty_s, rsp_acc_s, rsp_dec_s, byp_s, valid_s, pop_s, wr_s;
  logic [`XLEN-1:0]   head_pc_s, head_inst_s;
  logic               head_taken_s;

  assign fifo_cnt_s = wr_ptr_r - rd_ptr_r;
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  // Entries held plus responses still owed: credit guarantees every accepted response a slot
  assign occ_s      = 32'(fifo_cnt_s) + 32'(outst_cnt_r);

  assign ifu_req_credit = ~flush_req & (outst_cnt_r < CW'(MAX_OUTST)) & (occ_s < 32'(DEPTH));
  assign ibuf_empty     = empty_s & (outst_cnt_r == {CW{1'b0}});

  assign rsp_dec_s = ifu_rsp_valid & (outst_cnt_r != {CW{1'b0}});
  assign rsp_acc_s = rsp_dec_s & (drop_cnt_r == {CW{1'b0}}) & ~flush_req;

`ifdef LIEAT_IBUF_BYPASS_EN
  assign byp_s = empty_s & rsp_acc_s;
`else
  assign byp_s = 1'b0;
`endif

  assign valid_s = (~empty_s | byp_s) & ~flush_req;
  assign pop_s   = valid_s & id_i_ready & ~empty_s;
  assign wr_s    = rsp_acc_s & ~(byp_s & id_i_ready);

  // Head selection: stored entry, or the incoming response when bypassing an empty FIFO
  always_comb begin
    head_pc_s    = pc_mem_r[rd_ptr_r[AW-1:0]];
    head_inst_s  = inst_mem_r[rd_ptr_r[AW-1:0]];
    head_taken_s = taken_mem_r[rd_ptr_r[AW-1:0]];
    if (empty_s) begin
      head_pc_s    = ifu_rsp_pc;
      head_inst_s  = ifu_rsp_inst;
      head_taken_s = ifu_rsp_prdt_taken;
    end else begin
      head_pc_s    = pc_mem_r[rd_ptr_r[AW-1:0]];
      head_inst_s  = inst_mem_r[rd_ptr_r[AW-1:0]];
      head_taken_s = taken_mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Decode-side outputs, payload zeroed whenever nothing is offered
  always_comb begin
    id_i_valid      = valid_s;
    id_i_pc         = {`XLEN{1'b0}};
    id_i_inst       = {`XLEN{1'b0}};
    id_i_prdt_taken = 1'b0;
    if (valid_s) begin
      id_i_pc         = head_pc_s;
      id_i_inst       = head_inst_s;
      id_i_prdt_taken = head_taken_s;
    end else begin
      id_i_pc         = {`XLEN{1'b0}};
      id_i_inst       = {`XLEN{1'b0}};
      id_i_prdt_taken = 1'b0;
    end
  end

  // Pointers, outstanding-request count and post-flush drop count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      outst_cnt_r <= {CW{1'b0}};
      drop_cnt_r  <= {CW{1'b0}};
    end else begin
      if (flush_req) begin
        wr_ptr_r   <= {(AW+1){1'b0}};
        rd_ptr_r   <= {(AW+1){1'b0}};
        // Every request still owed after this cycle belongs to the flushed path
        drop_cnt_r <= outst_cnt_r - CW'(rsp_dec_s);
      end else begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(wr_s);
        rd_ptr_r <= rd_ptr_r + (AW+1)'(pop_s);
        if (ifu_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
          drop_cnt_r <= drop_cnt_r - CW'(1'b1);
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end
      case ({ifu_req_sh, rsp_dec_s})
        2'b10:   outst_cnt_r <= outst_cnt_r + CW'(1'b1);
        2'b01:   outst_cnt_r <= outst_cnt_r - CW'(1'b1);
        default: outst_cnt_r <= outst_cnt_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, reads are gated by the pointers
  always_ff @(posedge clock) begin
    if (wr_s) begin
      pc_mem_r[wr_ptr_r[AW-1:0]]    <= ifu_rsp_pc;
      inst_mem_r[wr_ptr_r[AW-1:0]]  <= ifu_rsp_inst;
      taken_mem_r[wr_ptr_r[AW-1:0]] <= ifu_rsp_prdt_taken;
    end
  end

endmodule

// File: tb/tb_lieat_ifu_ibuf.sv
// Randomized and directed bench for lieat_ifu_ibuf against a queue-based model of the
// buffer plus a memory-side model that returns responses in request order.
`ifndef XLEN
`define XLEN 32
`endif

module tb_lieat_ifu_ibuf;
  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 4;

  typedef struct {
    logic [`XLEN-1:0] pc;
    logic [`XLEN-1:0] inst;
    logic             tk;
  } ent_t;

  logic clock = 1'b0, reset = 1'b0;
  logic flush_req = 1'b0, ifu_req_sh = 1'b0, ifu_rsp_valid = 1'b0, ifu_rsp_prdt_taken = 1'b0;
  logic [`XLEN-1:0] ifu_rsp_pc = '0, ifu_rsp_inst = '0;
  logic id_i_ready = 1'b0;
  logic ifu_req_credit, id_i_valid, id_i_prdt_taken, ibuf_empty;
  logic [`XLEN-1:0] id_i_pc, id_i_inst;

  lieat_ifu_ibuf #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clock(clock), .reset(reset), .flush_req(flush_req), .ifu_req_credit(ifu_req_credit),
    .ifu_req_sh(ifu_req_sh), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_pc(ifu_rsp_pc),
    .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_prdt_taken(ifu_rsp_prdt_taken),
    .id_i_valid(id_i_valid), .id_i_ready(id_i_ready), .id_i_pc(id_i_pc),
    .id_i_inst(id_i_inst), .id_i_prdt_taken(id_i_prdt_taken), .ibuf_empty(ibuf_empty)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  ent_t q[$];       // buffer contents in decode order
  ent_t pend[$];    // memory side: requests awaiting a response
  int outst = 0, drop = 0;
  logic [`XLEN-1:0] next_pc = 32'h8000_0000;
  logic log_en = 1'b0;
  logic [`XLEN-1:0] pop_log[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_credit(input logic f);
    return !f && (outst < MAX_OUTST) && (q.size() + outst < DEPTH);
  endfunction

  // One cycle: drive at negedge, check combinational outputs, advance the model
  task automatic step(input logic f, input logic s, input logic r, input logic rdy);
    ent_t rsp, e, hd;
    logic acc, byp, ev;
    int sz;
    @(negedge clock);
    rsp.pc = '0; rsp.inst = '0; rsp.tk = 1'b0;
    if (r) rsp = pend.pop_front();
    if (s) begin
      e.pc = next_pc; e.inst = $urandom; e.tk = 1'($urandom);
      pend.push_back(e);
      next_pc = next_pc + 32'd4;
    end
    flush_req = f; ifu_req_sh = s; id_i_ready = rdy; ifu_rsp_valid = r;
    ifu_rsp_pc = rsp.pc; ifu_rsp_inst = rsp.inst; ifu_rsp_prdt_taken = rsp.tk;
    #1;
    sz  = q.size();
    acc = r && (drop == 0) && !f && (outst > 0);
    byp = 1'b0;
`ifdef LIEAT_IBUF_BYPASS_EN
    byp = (sz == 0) && acc;
`endif
    ev = ((sz > 0) || byp) && !f;
    hd.pc = '0; hd.inst = '0; hd.tk = 1'b0;
    if (ev) hd = (sz > 0) ? q[0] : rsp;
    check_eq("credit", ifu_req_credit, model_credit(f));
    check_eq("valid", id_i_valid, ev);
    check_eq("pc", id_i_pc, hd.pc);
    check_eq("inst", id_i_inst, hd.inst);
    check_eq("taken", id_i_prdt_taken, hd.tk);
    check_eq("empty", ibuf_empty, (sz == 0) && (outst == 0));
    if (log_en && id_i_valid && id_i_ready) pop_log.push_back(id_i_pc);
    if (f) begin
      drop = outst - (r ? 1 : 0);
      q.delete();
    end else begin
      if (r && drop > 0) drop--;
      if (ev && rdy && sz > 0) void'(q.pop_front());
      if (acc && !(byp && rdy)) q.push_back(rsp);
    end
    outst = outst + (s ? 1 : 0) - (r ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    flush_req = 1'b0; ifu_req_sh = 1'b0; ifu_rsp_valid = 1'b0; id_i_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_valid", id_i_valid, 1'b0);
    check_eq("rst_pc", id_i_pc, '0);
    check_eq("rst_credit", ifu_req_credit, 1'b1);
    check_eq("rst_empty", ibuf_empty, 1'b1);
    q.delete(); pend.delete(); outst = 0; drop = 0;
    next_pc = 32'h8000_0000;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic f, s, r, rdy;
    // Four back-to-back requests, in-order delivery
    do_reset();
    log_en = 1'b1;
    step(0, 1, 0, 1); step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
    step(0, 0, 1, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    log_en = 1'b0;
    check_eq("pop_count", pop_log.size(), 4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      check_eq("pop_order", pop_log[i], 32'h8000_0000 + 32'(4 * i));

    // Credit exhaustion with decode stalled
    do_reset();
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
    @(posedge clock); #1;
    check_eq("full_credit", ifu_req_credit, 1'b0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    @(posedge clock); #1;
    check_eq("credit_back", ifu_req_credit, 1'b1);
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);

    // Flush with three requests in flight, no response in the flush cycle
    do_reset();
    step(0, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    next_pc = 32'h8000_1000;
    step(0, 1, 1, 1); step(0, 0, 1, 1); step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    @(posedge clock); #1;
    check_eq("post_flush_valid", id_i_valid, 1'b1);
    check_eq("post_flush_pc", id_i_pc, 32'h8000_1000);
    step(0, 0, 0, 1);

    // Flush coinciding with a response, two outstanding
    do_reset();
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 0, 1, 1); step(0, 0, 1, 1);
    @(posedge clock); #1;
    check_eq("drop_valid", id_i_valid, 1'b0);
    check_eq("drop_empty", ibuf_empty, 1'b1);

    // Simultaneous write and pop with two stored entries
    do_reset();
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 1, 1); step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      f   = ($urandom % 20) == 0;
      s   = model_credit(f) && (($urandom % 4) != 0);
      r   = (pend.size() > 0) && (($urandom % 3) != 0);
      rdy = ($urandom % 3) != 0;
      step(f, s, r, rdy);
      if (f) next_pc = 32'($urandom) & 32'hFFFF_FFFC;
    end

    // Asynchronous reset in mid-stream, away from any clock edge
    step(0, model_credit(1'b0), pend.size() > 0, 1'b0);
    @(negedge clock);
    flush_req = 1'b0; ifu_req_sh = 1'b0; ifu_rsp_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_eq("async_valid", id_i_valid, 1'b0);
    check_eq("async_credit", ifu_req_credit, 1'b1);
    check_eq("async_empty", ibuf_empty, 1'b1);
    q.delete(); pend.delete(); outst = 0; drop = 0;
    @(negedge clock);
    reset = 1'b1;
    step(0, 1, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
